// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port between the fetch (ibus) and load/store (dbus) masters.
// Counts RAM wait states, absorbs the downstream RMW stall, and reports completion as per-master stall.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_addr,
    input  logic        ibus_read,
    output logic [31:0] ibus_rdata,
    output logic        ibus_stall,
    input  logic [31:0] dbus_addr,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wdata,
    output logic [31:0] dbus_rdata,
    output logic        dbus_stall,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_byteenable,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_stall
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef enum logic {
        LG_IBUS = 1'b0,
        LG_DBUS = 1'b1
    } grant_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    grant_t           last_grant;
    grant_t           last_grant_next;

    logic dbus_req;
    logic complete;
    logic grant_i;
    logic grant_d;

    assign dbus_req = dbus_read | dbus_write;
    // An access finishes once all wait states have elapsed and the downstream stage is not holding us.
    assign complete = (count == '0) & ~ram_stall;
    assign grant_i  = (state == GRANT_I);
    assign grant_d  = (state == GRANT_D);

    // State, wait counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            last_grant <= LG_IBUS;
        end else begin
            state      <= state_next;
            count      <= count_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state, counter and arbitration decision.
    always_comb begin
        state_next      = state;
        count_next      = count;
        last_grant_next = last_grant;

        case (state)
            IDLE: begin
                if (dbus_req && (!ibus_read || last_grant == LG_IBUS)) begin
                    state_next      = GRANT_D;
                    count_next      = CNT_LOAD;
                    last_grant_next = LG_DBUS;
                end else if (ibus_read) begin
                    state_next      = GRANT_I;
                    count_next      = CNT_LOAD;
                    last_grant_next = LG_IBUS;
                end
            end

            GRANT_I: begin
                if (!ibus_read || complete) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (!ram_stall && count != '0) begin
                    count_next = count - CNT_W'(1);
                end
            end

            GRANT_D: begin
                if (!dbus_req || complete) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (!ram_stall && count != '0) begin
                    count_next = count - CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Downstream drive: the granted master's fields, everything low when idle.
    always_comb begin
        ram_addr       = '0;
        ram_byteenable = '0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_wdata      = '0;

        if (grant_i) begin
            ram_addr       = ibus_addr;
            ram_byteenable = 4'b1111;
            ram_read       = ibus_read;
        end else if (grant_d) begin
            ram_addr       = dbus_addr;
            ram_byteenable = dbus_byteenable;
            ram_write      = dbus_write;
            ram_read       = dbus_read & ~dbus_write;
            ram_wdata      = dbus_wdata;
        end
    end

    assign ibus_stall = ibus_read & ~(grant_i & complete);
    assign dbus_stall = dbus_req  & ~(grant_d & complete);

    assign ibus_rdata = grant_i ? ram_rdata : '0;
    assign dbus_rdata = grant_d ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: three instances (WAIT_CYCLES 1, 2, 3) share one stimulus set,
// and each scenario resets all of them and checks the instance whose wait count it targets.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_addr;
    logic        ibus_read;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_wdata;
    logic [31:0] ram_rdata;
    logic        ram_stall;

    logic [31:0] w1_ibus_rdata, w2_ibus_rdata, w3_ibus_rdata;
    logic        w1_ibus_stall, w2_ibus_stall, w3_ibus_stall;
    logic [31:0] w1_dbus_rdata, w2_dbus_rdata, w3_dbus_rdata;
    logic        w1_dbus_stall, w2_dbus_stall, w3_dbus_stall;
    logic [31:0] w1_ram_addr, w2_ram_addr, w3_ram_addr;
    logic [3:0]  w1_ram_be, w2_ram_be, w3_ram_be;
    logic        w1_ram_read, w2_ram_read, w3_ram_read;
    logic        w1_ram_write, w2_ram_write, w3_ram_write;
    logic [31:0] w1_ram_wdata, w2_ram_wdata, w3_ram_wdata;

    int checks;
    int failures;

    mem_bus_arbiter #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .ibus_addr(ibus_addr), .ibus_read(ibus_read),
        .ibus_rdata(w1_ibus_rdata), .ibus_stall(w1_ibus_stall),
        .dbus_addr(dbus_addr), .dbus_byteenable(dbus_byteenable),
        .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_wdata(dbus_wdata),
        .dbus_rdata(w1_dbus_rdata), .dbus_stall(w1_dbus_stall),
        .ram_addr(w1_ram_addr), .ram_byteenable(w1_ram_be),
        .ram_read(w1_ram_read), .ram_write(w1_ram_write), .ram_wdata(w1_ram_wdata),
        .ram_rdata(ram_rdata), .ram_stall(ram_stall)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .ibus_addr(ibus_addr), .ibus_read(ibus_read),
        .ibus_rdata(w2_ibus_rdata), .ibus_stall(w2_ibus_stall),
        .dbus_addr(dbus_addr), .dbus_byteenable(dbus_byteenable),
        .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_wdata(dbus_wdata),
        .dbus_rdata(w2_dbus_rdata), .dbus_stall(w2_dbus_stall),
        .ram_addr(w2_ram_addr), .ram_byteenable(w2_ram_be),
        .ram_read(w2_ram_read), .ram_write(w2_ram_write), .ram_wdata(w2_ram_wdata),
        .ram_rdata(ram_rdata), .ram_stall(ram_stall)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .ibus_addr(ibus_addr), .ibus_read(ibus_read),
        .ibus_rdata(w3_ibus_rdata), .ibus_stall(w3_ibus_stall),
        .dbus_addr(dbus_addr), .dbus_byteenable(dbus_byteenable),
        .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_wdata(dbus_wdata),
        .dbus_rdata(w3_dbus_rdata), .dbus_stall(w3_dbus_stall),
        .ram_addr(w3_ram_addr), .ram_byteenable(w3_ram_be),
        .ram_read(w3_ram_read), .ram_write(w3_ram_write), .ram_wdata(w3_ram_wdata),
        .ram_rdata(ram_rdata), .ram_stall(ram_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ibus_addr       = '0;
        ibus_read       = 1'b0;
        dbus_addr       = '0;
        dbus_byteenable = '0;
        dbus_read       = 1'b0;
        dbus_write      = 1'b0;
        dbus_wdata      = '0;
        ram_rdata       = '0;
        ram_stall       = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with all DUTs in IDLE: that period is cycle 0.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state: ram side quiet, stalls follow raw requests.
        ibus_read  = 1'b1;
        dbus_write = 1'b1;
        ram_rdata  = 32'hDEADBEEF;
        #3;
        check("rst_ibus_stall", 32'(w1_ibus_stall), 32'd1);
        check("rst_dbus_stall", 32'(w1_dbus_stall), 32'd1);
        check("rst_ram_write",  32'(w1_ram_write),  32'd0);
        check("rst_ram_read",   32'(w1_ram_read),   32'd0);
        check("rst_ram_addr",   w1_ram_addr,        32'd0);
        check("rst_ibus_rdata", w1_ibus_rdata,      32'd0);
        check("rst_dbus_rdata", w1_dbus_rdata,      32'd0);

        // Single fetch, WAIT_CYCLES=1.
        do_reset();
        ibus_read = 1'b1;
        ibus_addr = 32'h0000_0100;
        ram_rdata = 32'h3C01_0001;
        settle();
        check("f_c0_stall",    32'(w1_ibus_stall), 32'd1);
        check("f_c0_ram_read", 32'(w1_ram_read),   32'd0);
        next_cycle();
        settle();
        check("f_c1_stall",    32'(w1_ibus_stall), 32'd0);
        check("f_c1_rdata",    w1_ibus_rdata,      32'h3C01_0001);
        check("f_c1_ram_read", 32'(w1_ram_read),   32'd1);
        check("f_c1_ram_addr", w1_ram_addr,        32'h0000_0100);
        check("f_c1_ram_be",   32'(w1_ram_be),     32'hF);
        next_cycle();
        ibus_read = 1'b0;
        settle();
        check("f_c2_ram_read", 32'(w1_ram_read),   32'd0);
        check("f_c2_rdata",    w1_ibus_rdata,      32'd0);

        // Tie after reset goes to dbus, then ibus wins the next tie.
        do_reset();
        ibus_read = 1'b1;
        ibus_addr = 32'h0000_0200;
        dbus_read = 1'b1;
        dbus_addr = 32'h0000_0300;
        ram_rdata = 32'hAAAA_5555;
        settle();
        check("t_c0_istall", 32'(w1_ibus_stall), 32'd1);
        check("t_c0_dstall", 32'(w1_dbus_stall), 32'd1);
        next_cycle();
        settle();
        check("t_c1_dstall", 32'(w1_dbus_stall), 32'd0);
        check("t_c1_istall", 32'(w1_ibus_stall), 32'd1);
        check("t_c1_addr",   w1_ram_addr,        32'h0000_0300);
        check("t_c1_drdata", w1_dbus_rdata,      32'hAAAA_5555);
        check("t_c1_irdata", w1_ibus_rdata,      32'd0);
        next_cycle();
        settle();
        check("t_c2_istall", 32'(w1_ibus_stall), 32'd1);
        check("t_c2_addr",   w1_ram_addr,        32'd0);
        next_cycle();
        settle();
        check("t_c3_istall", 32'(w1_ibus_stall), 32'd0);
        check("t_c3_dstall", 32'(w1_dbus_stall), 32'd1);
        check("t_c3_addr",   w1_ram_addr,        32'h0000_0200);
        check("t_c3_irdata", w1_ibus_rdata,      32'hAAAA_5555);

        // Partial store with one RMW stall cycle, WAIT_CYCLES=3: completes in cycle 4.
        do_reset();
        dbus_write      = 1'b1;
        dbus_byteenable = 4'b0010;
        dbus_addr       = 32'h0000_0400;
        dbus_wdata      = 32'h0000_AB00;
        settle();
        check("s_c0_dstall", 32'(w3_dbus_stall), 32'd1);
        check("s_c0_write",  32'(w3_ram_write),  32'd0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            ram_stall = (c == 1);
            settle();
            check($sformatf("s_c%0d_dstall", c), 32'(w3_dbus_stall), (c == 4) ? 32'd0 : 32'd1);
            check($sformatf("s_c%0d_write", c),  32'(w3_ram_write),  32'd1);
            check($sformatf("s_c%0d_be", c),     32'(w3_ram_be),     32'b0010);
            check($sformatf("s_c%0d_wdata", c),  w3_ram_wdata,       32'h0000_AB00);
        end
        next_cycle();
        dbus_write = 1'b0;
        settle();
        check("s_c5_write", 32'(w3_ram_write), 32'd0);

        // Continuous contention, WAIT_CYCLES=2: D,D,idle,I,I,idle repeating after cycle 0.
        do_reset();
        ibus_read = 1'b1;
        ibus_addr = 32'h0000_0500;
        dbus_read = 1'b1;
        dbus_addr = 32'h0000_0600;
        for (int c = 0; c < 30; c++) begin
            logic [31:0] exp_addr;
            logic        exp_ds;
            logic        exp_is;
            int          ph;
            if (c > 0) next_cycle();
            settle();
            ph       = (c == 0) ? 2 : (c - 1) % 6;
            exp_addr = (ph < 2) ? 32'h0000_0600 : ((ph == 3 || ph == 4) ? 32'h0000_0500 : 32'd0);
            exp_ds   = (ph != 1);
            exp_is   = (ph != 4);
            check($sformatf("rr_c%0d_addr", c),   w2_ram_addr,        exp_addr);
            check($sformatf("rr_c%0d_dstall", c), 32'(w2_dbus_stall), 32'(exp_ds));
            check($sformatf("rr_c%0d_istall", c), 32'(w2_ibus_stall), 32'(exp_is));
        end

        // Read and write together: write wins.
        do_reset();
        dbus_read       = 1'b1;
        dbus_write      = 1'b1;
        dbus_addr       = 32'h0000_0800;
        dbus_byteenable = 4'b1111;
        next_cycle();
        settle();
        check("rw_write", 32'(w1_ram_write), 32'd1);
        check("rw_read",  32'(w1_ram_read),  32'd0);

        // Fetch abort mid-grant, WAIT_CYCLES=3.
        do_reset();
        ibus_read = 1'b1;
        ibus_addr = 32'h0000_0700;
        next_cycle();
        settle();
        check("ab_c1_read",   32'(w3_ram_read),   32'd1);
        check("ab_c1_istall", 32'(w3_ibus_stall), 32'd1);
        next_cycle();
        ibus_read = 1'b0;
        settle();
        check("ab_c2_be",     32'(w3_ram_be),     32'hF);
        check("ab_c2_read",   32'(w3_ram_read),   32'd0);
        check("ab_c2_istall", 32'(w3_ibus_stall), 32'd0);
        next_cycle();
        settle();
        check("ab_c3_addr", w3_ram_addr,       32'd0);
        check("ab_c3_be",   32'(w3_ram_be),    32'd0);
        check("ab_c3_read", 32'(w3_ram_read),  32'd0);

        // Async reset during GRANT_D with counter=2, then the tie goes to dbus again.
        do_reset();
        ibus_read = 1'b1;
        ibus_addr = 32'h0000_0900;
        dbus_read = 1'b1;
        dbus_addr = 32'h0000_0A00;
        next_cycle();
        check("ar_pre_read", 32'(w3_ram_read), 32'd1);
        check("ar_pre_addr", w3_ram_addr,      32'h0000_0A00);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_read", 32'(w3_ram_read),  32'd0);
        check("ar_addr", w3_ram_addr,       32'd0);
        check("ar_be",   32'(w3_ram_be),    32'd0);
        #1;
        rst_n = 1'b1;
        settle();
        check("ar_idle_dstall", 32'(w3_dbus_stall), 32'd1);
        check("ar_idle_addr",   w3_ram_addr,        32'd0);
        next_cycle();
        settle();
        check("ar_regrant_addr", w3_ram_addr,        32'h0000_0A00);
        check("ar_regrant_read", 32'(w3_ram_read),   32'd1);
        check("ar_regrant_istl", 32'(w3_ibus_stall), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single unified RAM port between the instruction-fetch master (ibus, read-only) and the load/store master (dbus, read/write with byte enables). The selected request is presented to the downstream byte-conversion stage, which handles partial-word writes. The arbiter counts RAM wait states and absorbs that stage's read-modify-write stall. Each master sees a single stall signal: low means its access completes this cycle.

## Interface
- WAIT_CYCLES, 1, RAM access cycles per word access (legal range 1..15); counter is 4 bits.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ibus_addr  in  32  fetch address
- ibus_read  in  1  fetch request
- ibus_rdata  out  32  fetch data; valid in the completion cycle
- ibus_stall  out  1  fetch not complete this cycle
- dbus_addr  in  32  load/store address
- dbus_byteenable  in  4  store byte lanes
- dbus_read  in  1  load request
- dbus_write  in  1  store request
- dbus_wdata  in  32  store data
- dbus_rdata  out  32  load data; valid in the completion cycle
- dbus_stall  out  1  load/store not complete this cycle
- ram_addr  out  32  downstream address
- ram_byteenable  out  4  downstream byte enables
- ram_read  out  1  downstream read strobe
- ram_write  out  1  downstream write strobe
- ram_wdata  out  32  downstream write data
- ram_rdata  in  32  downstream read data
- ram_stall  in  1  downstream extra-cycle request (RMW read phase)

## Operation
- State machine:
  - IDLE: a request is pending → GRANT_I or GRANT_D at the next edge; no request → stay in IDLE.
  - GRANT_I / GRANT_D: on completion → IDLE. If the granted master drops its request → IDLE (abort).
- Arbitration is round-robin on a 1-bit last_grant register:
  - Reset value of last_grant is IBUS, so the first tie goes to dbus.
  - last_grant updates on every grant.
  - A lone requester always wins.
- On grant, the wait counter loads WAIT_CYCLES-1.
- Counter updates:
  - Decrements when ram_stall=0 and counter≠0.
  - Holds while ram_stall=1.
- Completion cycle: granted state, counter=0, ram_stall=0, and the master's request still high.
- Downstream drive:
  - In GRANT_I: ram_addr=ibus_addr, ram_read=ibus_read, ram_write=0, ram_byteenable=4'b1111, ram_wdata=0.
  - In GRANT_D: all dbus fields pass through.
  - dbus_read and dbus_write both high: write wins, ram_read forced 0.
  - In IDLE, all ram_* outputs are 0.
- Stall outputs: x_stall = x request active AND NOT (granted to x AND completion cycle). A requester that is not granted is always stalled.
- Read data: ibus_rdata=ram_rdata in GRANT_I, otherwise 0; dbus_rdata likewise in GRANT_D. Combinational; no registering.
- Masters must hold address, data and strobes stable until their stall is low. Violations cause an abort; the downstream result is undefined.

## Timing
- Reset (async): state=IDLE, counter=0, last_grant=IBUS. All ram_* outputs are 0 and rdata outputs are 0. Stalls equal the raw request inputs.
- Request raised in IDLE in cycle 0: grant at edge 0→1; completion earliest in cycle WAIT_CYCLES.
- Each ram_stall=1 cycle adds one cycle of latency.
- After completion there is always one IDLE turnaround cycle. Peak throughput is one access per WAIT_CYCLES+1 cycles per grant, plus ram_stall cycles.
- A new request arriving during a grant waits; it is never preempted.
- Reset asserted mid-access returns immediately to IDLE with downstream strobes low. The RAM may hold a partial RMW result.

## Test plan
- WAIT_CYCLES=1; ibus_read=1 with addr 0x00000100 at cycle 0; ram_rdata=0x3C010001 → ibus_stall=1 in cycle 0, 0 in cycle 1; ibus_rdata=0x3C010001 in cycle 1; ram_read=1 only in cycle 1.
- WAIT_CYCLES=1; both masters request at the same cycle after reset → dbus granted first. After completion and turnaround, ibus is granted; ibus_stall stays 1 throughout the dbus access.
- WAIT_CYCLES=3; dbus_write, byteenable=4'b0010, ram_stall=1 for the first granted cycle only → dbus_stall falls 4 cycles after grant. ram_write=1 in every granted cycle; ram_byteenable=4'b0010.
- WAIT_CYCLES=2; continuous ibus and dbus requests for 30 cycles → grants alternate D,I,D,I; every grant lasts 2 cycles followed by 1 IDLE cycle.
- dbus_read and dbus_write both high → ram_write=1, ram_read=0. Separately, ibus drops its request mid-grant → IDLE at the next edge and all ram_* outputs are 0.
- rst_n pulsed low during GRANT_D with counter=2 → all ram_* outputs are 0 asynchronously. After release, the tie goes to dbus again.
